// File: rtl/control_sequencer.sv
// Instruction sequencer for a load / shift / write-back datapath.
// Every output is registered and decoded from the next state, so outputs line up with the state they belong to.
module control_sequencer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [CNT_W-1:0] amount,
  input  logic             shifter_flag,
  output logic [15:0]      control,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             carry,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] amt_q, amt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [15:0]      control_q, control_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h4);
  endfunction

  function automatic logic is_src_b(input logic [3:0] op);
    return (op == 4'h3) || (op == 4'h4);
  endfunction

  function automatic logic is_shr(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h3);
  endfunction

  // Handshake: start is accepted only on an edge where the FSM sits in IDLE;
  // while busy is high start is dropped, never queued, and opcode/amount are ignored.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    amt_d   = amt_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = opcode;
          amt_d   = amount;
          cnt_d   = amount;
          state_d = is_shift_op(opcode) ? S_LOAD : S_FINISH;
        end
      end
      S_LOAD: begin
        state_d = (amt_q != '0) ? S_SHIFT : S_WRITE;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        carry_d = is_shr(op_q) ? shifter_flag : 1'b0;
        state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state and the opcode that will be latched with it.
  always_comb begin
    control_d = '0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FINISH);
    err_d     = (state_d == S_FINISH) && (op_d != 4'h0) && !is_shift_op(op_d);
    case (state_d)
      S_LOAD: begin
        control_d[2] = is_src_b(op_d);
        control_d[3] = !is_src_b(op_d);
        control_d[4] = is_src_b(op_d);
      end
      S_SHIFT: begin
        control_d[5] = is_shr(op_d);
        control_d[6] = !is_shr(op_d);
      end
      S_WRITE: begin
        control_d[7] = !is_src_b(op_d);
        control_d[8] = is_src_b(op_d);
      end
      default: begin
        control_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      amt_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      control_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      amt_q     <= amt_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      control_q <= control_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign control     = control_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign carry       = carry_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected {control, done, err, carry}
// records are queued by the driver and popped by a monitor on every busy cycle.
module tb_control_sequencer;

  localparam int CNT_W = 3;
  localparam int W     = 19;

  logic             clk;
  logic             reset;
  logic             start;
  logic [3:0]       opcode;
  logic [CNT_W-1:0] amount;
  logic             shifter_flag;
  logic [15:0]      control;
  logic             busy;
  logic             done;
  logic             err;
  logic             carry;
  logic [2:0]       dbg_state_o;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  logic         model_carry;

  control_sequencer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .opcode       (opcode),
    .amount       (amount),
    .shifter_flag (shifter_flag),
    .control      (control),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .carry        (carry),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected per-cycle record stream for one accepted instruction.
  task automatic push_op(input logic [3:0] op, input int amt, input logic flag);
    logic        src_b, shr;
    logic [15:0] ld, sh, wr;
    if (!(op >= 4'h1 && op <= 4'h4)) begin
      exp_q.push_back({16'h0000, 1'b1, (op != 4'h0), model_carry});
      return;
    end
    src_b = (op == 4'h3) || (op == 4'h4);
    shr   = (op == 4'h1) || (op == 4'h3);
    ld    = src_b ? 16'h0014 : 16'h0008;
    sh    = shr   ? 16'h0020 : 16'h0040;
    wr    = src_b ? 16'h0100 : 16'h0080;
    exp_q.push_back({ld, 1'b0, 1'b0, model_carry});
    for (int i = 0; i < amt; i++) exp_q.push_back({sh, 1'b0, 1'b0, model_carry});
    exp_q.push_back({wr, 1'b0, 1'b0, model_carry});
    model_carry = shr ? flag : 1'b0;
    exp_q.push_back({16'h0000, 1'b1, 1'b0, model_carry});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) begin
      @(posedge clk); #1;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %b after 60 cycles, required 0", busy);
    end
  endtask

  // driver: issue one instruction; returns just after the accept edge
  task automatic run_op(input logic [3:0] op, input int amt, input logic flag);
    wait_idle();
    start        = 1'b1;
    opcode       = op;
    amount       = CNT_W'(amt);
    shifter_flag = flag;
    push_op(op, amt, flag);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_busy: control=%h done=%b with empty expected queue", control, done);
        end else begin
          check("busy_cycle", {control, done, err, carry}, exp_q.pop_front());
        end
      end else begin
        check("idle_quiet", {control, done, err, 1'b0}, {16'h0000, 3'b000});
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    model_carry  = 1'b0;
    reset        = 1'b1;
    start        = 1'b1;
    opcode       = 4'h1;
    amount       = '0;
    shifter_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset wins over start: still idle and cleared
    check("reset_state", {control, busy, done, err}, {16'h0000, 3'b000});
    check("reset_carry_state", {16'h0, carry, dbg_state_o}, {16'h0, 1'b0, 3'd0});
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(4'h1, 3, 1'b1);   // SHR A x3, carry <- 1
    run_op(4'h4, 0, 1'b0);   // SHL B, no shift cycles
    run_op(4'h3, 2, 1'b1);   // SHR B x2, carry <- 1
    run_op(4'h9, 0, 1'b0);   // illegal, carry held
    run_op(4'h0, 5, 1'b0);   // NOP
    run_op(4'h2, 1, 1'b1);   // SHL A, carry <- 0
    run_op(4'hF, 7, 1'b1);   // illegal
    run_op(4'h3, 7, 1'b1);   // max shift count

    // start pulse mid-instruction with different opcode/amount is ignored
    run_op(4'h1, 4, 1'b0);
    @(posedge clk); #1;
    start  = 1'b1;
    opcode = 4'h4;
    amount = 3'd1;
    @(posedge clk); #1;
    start  = 1'b0;
    opcode = 4'h9;

    // start held: back-to-back launches with one IDLE cycle between
    wait_idle();
    start  = 1'b1;
    opcode = 4'h2;
    amount = 3'd1;
    push_op(4'h2, 1, 1'b0);
    push_op(4'h2, 1, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("b2b_gap_idle", {18'h0, busy}, {18'h0, 1'b0});
    @(posedge clk); #1;
    check("b2b_relaunch", {18'h0, busy}, {18'h0, 1'b1});
    start = 1'b0;

    // reset during SHIFT aborts with no done
    run_op(4'h1, 7, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    model_carry = 1'b0;
    reset = 1'b0;
    check("abort_state", {control, busy, done, err}, {16'h0000, 3'b000});
    check("abort_carry", {18'h0, carry}, {18'h0, 1'b0});
    repeat (3) begin
      @(posedge clk); #1;
    end
    run_op(4'h1, 1, 1'b1);   // runs normally after abort
    run_op(4'h4, 2, 1'b0);

    wait_idle();
    @(posedge clk); #1;
    check("queue_drained", W'(exp_q.size()), W'(0));
    check("final_carry", {18'h0, carry}, {18'h0, model_carry});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
